mem_bus_arbiter: RTL and testbench

- Two-port arbiter that shares the single memory_bus between requester 0 (CPU core) and requester 1 (DMA/video fetch).
- Latches one request at a time and drives the memory_bus address, data, enable and write-enable lines.
- Stalls on bus_halt from the slow SD/flash bank and returns read data with a one-cycle ack.
- A watchdog aborts any access whose halt outlasts a limit, so a hung SD card cannot lock the system.

---
 rtl/mem_bus_arbiter_pkg.sv | 17 +
 rtl/mem_bus_watchdog.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared state encoding, port indices and defaults for mem_bus_arbiter.
// Optional build macro: MEM_BUS_ARBITER_ROUND_ROBIN_EN (used by mem_bus_arbiter).
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    localparam logic [7:0] ERR_DATA_DEFAULT = 8'hff;

endpackage

// File: rtl/mem_bus_watchdog.sv
// Saturating halt watchdog: counts stalled cycles, flags when the count reaches TIMEOUT.
module mem_bus_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != LIMIT)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory_bus arbiter (CPU port 0, DMA port 1) with halt stall and timeout abort.
// Build macro MEM_BUS_ARBITER_ROUND_ROBIN_EN selects round-robin ties; default is fixed priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int         TIMEOUT  = 1024,
    parameter logic [7:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic        req_1,
    input  logic [23:0] addr_0,
    input  logic [23:0] addr_1,
    input  logic [7:0]  wdata_0,
    input  logic [7:0]  wdata_1,
    input  logic        we_0,
    input  logic        we_1,
    output logic        ack_0,
    output logic        ack_1,
    output logic [7:0]  rdata,
    output logic        err,
    output logic [23:0] mem_address,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out,
    output logic        mem_bus_enable,
    output logic        mem_write_enable,
    input  logic        mem_bus_halt
);

    arb_state_t r_state;
    arb_state_t w_state_next;

    logic [23:0] r_addr;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic        r_we;
    logic        r_grant;
    logic        r_last_grant;
    logic        r_err;

    logic w_grant;
    logic w_latch;
    logic w_capture;
    logic w_timeout;
    logic w_wd_clear;
    logic w_wd_inc;
    logic w_wd_expired;

    always_comb begin : grant_select
        w_grant = PORT_CPU;
        if (req_0 && req_1) begin
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
            w_grant = ~r_last_grant;
`else
            w_grant = PORT_CPU;
`endif
        end else if (req_1) begin
            w_grant = PORT_DMA;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin : fsm_next
        w_state_next     = r_state;
        w_latch          = 1'b0;
        w_capture        = 1'b0;
        w_timeout        = 1'b0;
        w_wd_clear       = 1'b0;
        w_wd_inc         = 1'b0;
        mem_bus_enable   = 1'b0;
        mem_write_enable = 1'b0;
        ack_0            = 1'b0;
        ack_1            = 1'b0;
        err              = 1'b0;
        case (r_state)
            IDLE: begin
                w_wd_clear = 1'b1;
                if (req_0 || req_1) begin
                    w_latch      = 1'b1;
                    w_state_next = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                mem_bus_enable   = 1'b1;
                mem_write_enable = r_we;
                if (!mem_bus_halt) begin
                    w_capture    = 1'b1;
                    w_state_next = DONE;
                end else if ((r_state == WAIT) && w_wd_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = DONE;
                end else begin
                    w_wd_inc     = 1'b1;
                    w_state_next = WAIT;
                end
            end
            DONE: begin
                ack_0        = (r_grant == PORT_CPU);
                ack_1        = (r_grant == PORT_DMA);
                err          = r_err;
                w_wd_clear   = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_we         <= 1'b0;
            r_grant      <= PORT_CPU;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_last_grant <= PORT_DMA;
        end else begin
            if (w_latch) begin
                r_grant <= w_grant;
                r_addr  <= (w_grant == PORT_DMA) ? addr_1  : addr_0;
                r_wdata <= (w_grant == PORT_DMA) ? wdata_1 : wdata_0;
                r_we    <= (w_grant == PORT_DMA) ? we_1    : we_0;
                r_err   <= 1'b0;
            end
            if (w_capture && !r_we) begin
                r_rdata <= mem_data_out;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
                if (!r_we) begin
                    r_rdata <= ERR_DATA;
                end
            end
            // last_grant tracked in both arbitration modes; only round-robin consults it
            if ((r_state == DONE) && (r_last_grant != r_grant)) begin
                r_last_grant <= r_grant;
            end
        end
    end

    mem_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_clear   (w_wd_clear),
        .i_inc     (w_wd_inc),
        .o_expired (w_wd_expired)
    );

    assign mem_address = r_addr;
    assign mem_data_in = r_wdata;
    assign rdata       = r_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed cases plus randomized transactions
// checked against a transaction-level latency/arbitration model.
module tb_mem_bus_arbiter;

    localparam int unsigned T   = 16;
    localparam logic [7:0]  ERR = 8'hFF;

    logic        clk;
    logic        reset;
    logic        req_0, req_1;
    logic [23:0] addr_0, addr_1;
    logic [7:0]  wdata_0, wdata_1;
    logic        we_0, we_1;
    logic        ack_0, ack_1;
    logic [7:0]  rdata;
    logic        err;
    logic [23:0] mem_address;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        mem_bus_enable;
    logic        mem_write_enable;
    logic        mem_bus_halt;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [23:0] t_addr [2];
    logic [7:0]  t_wdata[2];
    logic [7:0]  t_rd   [2];
    logic        t_we   [2];
    int unsigned t_h    [2];

    int unsigned m_last  = 1;
    logic [7:0]  m_rdata = 8'h00;

    mem_bus_arbiter #(
        .TIMEOUT  (T),
        .ERR_DATA (ERR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_0            (req_0),
        .req_1            (req_1),
        .addr_0           (addr_0),
        .addr_1           (addr_1),
        .wdata_0          (wdata_0),
        .wdata_1          (wdata_1),
        .we_0             (we_0),
        .we_1             (we_1),
        .ack_0            (ack_0),
        .ack_1            (ack_1),
        .rdata            (rdata),
        .err              (err),
        .mem_address      (mem_address),
        .mem_data_in      (mem_data_in),
        .mem_data_out     (mem_data_out),
        .mem_bus_enable   (mem_bus_enable),
        .mem_write_enable (mem_write_enable),
        .mem_bus_halt     (mem_bus_halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int unsigned stall_cycles(input int unsigned h);
        return (h > T) ? T : h;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ack_0"}, 32'(ack_0), 32'd0);
        check({tag, "_ack_1"}, 32'(ack_1), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        check({tag, "_mem_data_in"}, 32'(mem_data_in), 32'd0);
        check({tag, "_mem_bus_enable"}, 32'(mem_bus_enable), 32'd0);
        check({tag, "_mem_write_enable"}, 32'(mem_write_enable), 32'd0);
    endtask

    task automatic drive_fields();
        addr_0  = t_addr[0];  addr_1  = t_addr[1];
        wdata_0 = t_wdata[0]; wdata_1 = t_wdata[1];
        we_0    = t_we[0];    we_1    = t_we[1];
    endtask

    // Raise the requests in mask during an IDLE cycle (cycle 0) and follow both accesses to ack.
    task automatic run_pair(input logic [1:0] mask, input bit drop_early);
        int unsigned ord[2];
        int unsigned n, k, cyc, cnt, act, exp_cyc;
        bit          e;
        if (mask == 2'b11) begin
`ifdef MEM_BUS_ARBITER_ROUND_ROBIN_EN
            ord[0] = (m_last == 0) ? 1 : 0;
`else
            ord[0] = 0;
`endif
            ord[1] = 1 - ord[0];
            n = 2;
        end else begin
            ord[0] = mask[1] ? 1 : 0;
            ord[1] = ord[0];
            n = 1;
        end
        @(posedge clk); #1;
        drive_fields();
        req_0 = mask[0];
        req_1 = mask[1];
        mem_bus_halt = 1'b0;
        k = 0; cyc = 0; cnt = 0;
        exp_cyc = 2 + stall_cycles(t_h[ord[0]]);
        while (k < n && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            act = ord[k];
            if (drop_early && cyc == 1) begin
                req_0 = 1'b0;
                req_1 = 1'b0;
            end
            if (mem_bus_enable) begin
                check("mem_address", 32'(mem_address), 32'(t_addr[act]));
                check("mem_data_in", 32'(mem_data_in), 32'(t_wdata[act]));
                check("mem_write_enable", 32'(mem_write_enable), 32'(t_we[act]));
                mem_bus_halt = (cnt < t_h[act]);
                mem_data_out = t_rd[act];
                cnt++;
            end else begin
                mem_bus_halt = 1'b0;
                check("we_without_enable", 32'(mem_write_enable), 32'd0);
            end
            if (ack_0 || ack_1 || err) begin
                e = (t_h[act] > T);
                if (!t_we[act]) m_rdata = e ? ERR : t_rd[act];
                check("ack_0", 32'(ack_0), 32'(act == 0));
                check("ack_1", 32'(ack_1), 32'(act == 1));
                check("ack_cycle", cyc, exp_cyc);
                check("err", 32'(err), 32'(e));
                check("rdata", 32'(rdata), 32'(m_rdata));
                m_last = act;
                if (act == 0) req_0 = 1'b0; else req_1 = 1'b0;
                k++;
                cnt = 0;
                if (k < n) exp_cyc = cyc + 3 + stall_cycles(t_h[ord[1]]);
            end
        end
        if (k < n) check("ack_timeout", k, n);
    endtask

    initial begin
        reset = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0;
        addr_0 = '0; addr_1 = '0;
        wdata_0 = '0; wdata_1 = '0;
        we_0 = 1'b0; we_1 = 1'b0;
        mem_data_out = 8'h00;
        mem_bus_halt = 1'b0;
        for (int p = 0; p < 2; p++) begin
            t_addr[p] = '0; t_wdata[p] = '0; t_rd[p] = '0; t_we[p] = 1'b0; t_h[p] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("reset");

        // port 0 read, no halt
        t_addr[0] = 24'h000010; t_wdata[0] = 8'h11; t_we[0] = 1'b0; t_h[0] = 0; t_rd[0] = 8'h5A;
        run_pair(2'b01, 1'b0);

        // port 1 write, rdata must keep 5A
        t_addr[1] = 24'h008003; t_wdata[1] = 8'h3C; t_we[1] = 1'b1; t_h[1] = 0; t_rd[1] = 8'h99;
        run_pair(2'b10, 1'b0);

        // simultaneous requests
        t_addr[0] = 24'h000020; t_we[0] = 1'b0; t_rd[0] = 8'h21;
        t_addr[1] = 24'h000030; t_we[1] = 1'b0; t_rd[1] = 8'h31;
        run_pair(2'b11, 1'b0);
        run_pair(2'b11, 1'b0);

        // five halted cycles
        t_addr[0] = 24'h010000; t_we[0] = 1'b0; t_h[0] = 5; t_rd[0] = 8'hC3;
        run_pair(2'b01, 1'b0);

        // halt stuck high: timeout, then a normal access
        t_addr[0] = 24'h020000; t_h[0] = 1000; t_rd[0] = 8'h42;
        run_pair(2'b01, 1'b0);
        t_addr[0] = 24'h020001; t_h[0] = 0; t_rd[0] = 8'h77;
        run_pair(2'b01, 1'b0);

        // halt released exactly at the limit: data wins, no err
        t_addr[1] = 24'h030000; t_we[1] = 1'b0; t_h[1] = T; t_rd[1] = 8'h6B;
        run_pair(2'b10, 1'b0);

        // request dropped after grant still completes
        t_addr[0] = 24'h040000; t_we[0] = 1'b1; t_wdata[0] = 8'hE1; t_h[0] = 2;
        run_pair(2'b01, 1'b1);

        // reset while in WAIT
        t_addr[0] = 24'h0ABCDE; t_we[0] = 1'b0; t_h[0] = 10;
        @(posedge clk); #1;
        drive_fields();
        req_0 = 1'b1;
        mem_bus_halt = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("wait_enable", 32'(mem_bus_enable), 32'd1);
        reset = 1'b1;
        req_0 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        mem_bus_halt = 1'b0;
        check_all_zero("mid_reset");
        m_rdata = 8'h00;
        m_last = 1;
        t_h[0] = 0; t_rd[0] = 8'h3E;
        run_pair(2'b01, 1'b0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++) begin
                t_addr[p]  = 24'($urandom);
                t_wdata[p] = 8'($urandom);
                t_rd[p]    = 8'($urandom);
                t_we[p]    = 1'($urandom);
                t_h[p]     = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 3);
            end
            run_pair(2'($urandom_range(1, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
